ep_bins_sequencer: RTL and testbench

//   Multi-cycle sequencer for CABAC bypass (EP) bin decoding in the VVC arithmetic decoder.
//   It takes a snapshot of the decoder state (m_value, m_range, m_bitsNeeded) and decodes
//   num_bins bypass bins at one bin per cycle. Bitstream bytes are pulled through a
//   req/ack handshake whenever m_bitsNeeded reaches 0.
//   It sits between the context engine and the byte reader and replaces the unrolled

---
 rtl/ep_bins_sequencer.sv | 150 +++++++++++++++
 tb/tb_ep_bins_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ep_bins_sequencer.sv
// Multi-cycle CABAC bypass (EP) bin decoder: decodes one bypass bin per cycle from a
// snapshot of the arithmetic decoder state, pulling bitstream bytes over req/ack as needed.
module ep_bins_sequencer #(
    parameter int MAX_BINS = 32,
    parameter int CNT_W    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_bins,
    input  logic [8:0]          m_range_in,
    input  logic [31:0]         m_value_in,
    input  logic signed [3:0]   m_bits_needed_in,
    output logic                byte_req,
    input  logic                byte_ack,
    input  logic [7:0]          byte_data,
    output logic                busy,
    output logic                done,
    output logic [MAX_BINS-1:0] bins_out,
    output logic [31:0]         m_value_out,
    output logic signed [3:0]   m_bits_needed_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BIN   = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BINS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]          state_reg, state_next;
    logic [31:0]         val_reg, val_next;
    logic [8:0]          range_reg, range_next;
    logic signed [3:0]   bn_reg, bn_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [MAX_BINS-1:0] bins_reg, bins_next;
    logic [MAX_BINS-1:0] bins_out_reg, bins_out_next;
    logic [31:0]         value_out_reg, value_out_next;
    logic signed [3:0]   bn_out_reg, bn_out_next;

    logic [31:0]       v;
    logic [31:0]       sr;
    logic signed [3:0] bn_inc;
    logic              resolve;
    logic              bin_bit;

    always_comb begin
        state_next     = state_reg;
        val_next       = val_reg;
        range_next     = range_reg;
        bn_next        = bn_reg;
        cnt_next       = cnt_reg;
        bins_next      = bins_reg;
        bins_out_next  = bins_out_reg;
        value_out_next = value_out_reg;
        bn_out_next    = bn_out_reg;
        v              = val_reg;
        sr             = {16'd0, range_reg, 7'd0};
        bn_inc         = bn_reg + 4'sd1;
        resolve        = 1'b0;
        bin_bit        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    val_next   = m_value_in;
                    range_next = m_range_in;
                    bn_next    = m_bits_needed_in;
                    cnt_next   = (num_bins > CNT_MAX) ? CNT_MAX : num_bins;
                    bins_next  = '0;
                    state_next = S_BIN;
                end
            end
            S_BIN: begin
                // A zero-length request passes through one empty BIN cycle so that
                // every request takes at least two cycles from start to done.
                if (cnt_reg == '0) begin
                    state_next = S_DONE;
                end else begin
                    v = val_reg << 1;
                    if (bn_inc >= 4'sd0) begin
                        val_next   = v;
                        state_next = S_FETCH;
                    end else begin
                        bn_next = bn_inc;
                        resolve = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (byte_ack) begin
                    v       = val_reg + {24'd0, byte_data};
                    bn_next = -4'sd8;
                    resolve = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (resolve) begin
            bin_bit    = (v >= sr);
            val_next   = bin_bit ? (v - sr) : v;
            bins_next  = {bins_reg[MAX_BINS-2:0], bin_bit};
            cnt_next   = cnt_reg - CNT_ONE;
            state_next = (cnt_reg == CNT_ONE) ? S_DONE : S_BIN;
        end

        // Results are captured on entry to DONE so they are valid while done is high.
        if (state_next == S_DONE && state_reg != S_DONE) begin
            bins_out_next  = bins_next;
            value_out_next = val_next;
            bn_out_next    = bn_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            val_reg       <= '0;
            range_reg     <= '0;
            bn_reg        <= '0;
            cnt_reg       <= '0;
            bins_reg      <= '0;
            bins_out_reg  <= '0;
            value_out_reg <= '0;
            bn_out_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            val_reg       <= val_next;
            range_reg     <= range_next;
            bn_reg        <= bn_next;
            cnt_reg       <= cnt_next;
            bins_reg      <= bins_next;
            bins_out_reg  <= bins_out_next;
            value_out_reg <= value_out_next;
            bn_out_reg    <= bn_out_next;
        end
    end

    assign byte_req          = (state_reg == S_FETCH);
    assign busy              = (state_reg != S_IDLE);
    assign done              = (state_reg == S_DONE);
    assign bins_out          = bins_out_reg;
    assign m_value_out       = value_out_reg;
    assign m_bits_needed_out = bn_out_reg;

endmodule

// File: tb/tb_ep_bins_sequencer.sv
// Directed bench for ep_bins_sequencer with hand-computed expected results.
module tb_ep_bins_sequencer;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [5:0]         num_bins;
    logic [8:0]         m_range_in;
    logic [31:0]        m_value_in;
    logic signed [3:0]  m_bits_needed_in;
    logic               byte_req;
    logic               byte_ack;
    logic [7:0]         byte_data;
    logic               busy;
    logic               done;
    logic [31:0]        bins_out;
    logic [31:0]        m_value_out;
    logic signed [3:0]  m_bits_needed_out;

    int checks;
    int failures;
    int lat;
    int req_cycles;
    bit got_done;

    ep_bins_sequencer #(.MAX_BINS(32), .CNT_W(6)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .num_bins          (num_bins),
        .m_range_in        (m_range_in),
        .m_value_in        (m_value_in),
        .m_bits_needed_in  (m_bits_needed_in),
        .byte_req          (byte_req),
        .byte_ack          (byte_ack),
        .byte_data         (byte_data),
        .busy              (busy),
        .done              (done),
        .bins_out          (bins_out),
        .m_value_out       (m_value_out),
        .m_bits_needed_out (m_bits_needed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Issue one request; optionally re-pulse start while busy and during DONE.
    task automatic run_req(input logic [8:0] rng, input logic [31:0] val,
                           input logic [3:0] bn, input logic [5:0] nb,
                           input int ack_wait, input logic [7:0] bdata, input bit glitch);
        @(negedge clk);
        m_range_in       = rng;
        m_value_in       = val;
        m_bits_needed_in = bn;
        num_bins         = nb;
        start            = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        lat        = 1;
        req_cycles = 0;
        got_done   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (glitch && lat == 1) begin
                start            = 1'b1;
                m_value_in       = 32'h1234_5678;
                m_range_in       = 9'd400;
                m_bits_needed_in = -4'sd2;
                num_bins         = 6'd0;
            end else begin
                start = 1'b0;
            end
            if (byte_req) begin
                req_cycles++;
                byte_ack  = (req_cycles > ack_wait);
                byte_data = bdata;
            end else begin
                byte_ack = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        byte_ack = 1'b0;
        check_val("done_seen", {63'd0, got_done}, 64'd1);
        check_val("req_at_done", {63'd0, byte_req}, 64'd0);
        if (glitch) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_val("done_one_cycle", {63'd0, done}, 64'd0);
            check_val("start_in_done_ignored", {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst_n            = 1'b0;
        start            = 1'b0;
        num_bins         = '0;
        m_range_in       = '0;
        m_value_in       = '0;
        m_bits_needed_in = '0;
        byte_ack         = 1'b0;
        byte_data        = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_req", {63'd0, byte_req}, 64'd0);
        check_val("rst_bins", {32'd0, bins_out}, 64'd0);
        check_val("rst_value", {32'd0, m_value_out}, 64'd0);
        rst_n = 1'b1;

        // 1: single bin, no fetch
        run_req(9'd256, 32'h0000_4000, 4'hB, 6'd1, 0, 8'h00, 1'b0);
        check_val("t1_bins", {32'd0, bins_out}, 64'h1);
        check_val("t1_value", {32'd0, m_value_out}, 64'h0);
        check_val("t1_bn", {60'd0, m_bits_needed_out}, 64'hC);
        check_val("t1_lat", 64'(lat), 64'd2);
        check_val("t1_noreq", 64'(req_cycles), 64'd0);

        // 2: four ones
        run_req(9'd256, 32'h0000_7FFF, 4'h8, 6'd4, 0, 8'h00, 1'b0);
        check_val("t2_bins", {32'd0, bins_out}, 64'hF);
        check_val("t2_value", {32'd0, m_value_out}, 64'h7FF0);
        check_val("t2_bn", {60'd0, m_bits_needed_out}, 64'hC);
        check_val("t2_lat", 64'(lat), 64'd5);

        // 3: fetch with ack held off 3 cycles
        run_req(9'd256, 32'h0, 4'hF, 6'd1, 3, 8'hFF, 1'b0);
        check_val("t3_bins", {32'd0, bins_out}, 64'h0);
        check_val("t3_value", {32'd0, m_value_out}, 64'hFF);
        check_val("t3_bn", {60'd0, m_bits_needed_out}, 64'h8);
        check_val("t3_req_cycles", 64'(req_cycles), 64'd4);
        check_val("t3_lat", 64'(lat), 64'd6);

        // 4: zero bins passes state through
        run_req(9'd300, 32'hDEAD_BEEF, 4'hD, 6'd0, 0, 8'h00, 1'b0);
        check_val("t4_bins", {32'd0, bins_out}, 64'h0);
        check_val("t4_value", {32'd0, m_value_out}, 64'hDEAD_BEEF);
        check_val("t4_bn", {60'd0, m_bits_needed_out}, 64'hD);
        check_val("t4_lat", 64'(lat), 64'd2);

        // mixed bits with range 300 (sr = 0x9600)
        run_req(9'd300, 32'h0000_5000, 4'hC, 6'd2, 0, 8'h00, 1'b0);
        check_val("mix_bins", {32'd0, bins_out}, 64'h2);
        check_val("mix_value", {32'd0, m_value_out}, 64'h1400);
        check_val("mix_bn", {60'd0, m_bits_needed_out}, 64'hE);
        check_val("mix_lat", 64'(lat), 64'd3);

        // saturation: 40 requested -> 32 bins, fetches at bins 8/16/24/32
        run_req(9'd256, 32'h0, 4'h8, 6'd40, 0, 8'h00, 1'b0);
        check_val("sat_lat", 64'(lat), 64'd37);
        check_val("sat_fetches", 64'(req_cycles), 64'd4);
        check_val("sat_bn", {60'd0, m_bits_needed_out}, 64'h8);

        // 5: start while busy and during DONE ignored
        run_req(9'd256, 32'h0000_7FFF, 4'h8, 6'd4, 0, 8'h00, 1'b1);
        check_val("t5_bins", {32'd0, bins_out}, 64'hF);
        check_val("t5_value", {32'd0, m_value_out}, 64'h7FF0);
        check_val("t5_lat", 64'(lat), 64'd5);

        // 6: reset during FETCH
        @(negedge clk);
        m_range_in       = 9'd256;
        m_value_in       = 32'h0;
        m_bits_needed_in = -4'sd1;
        num_bins         = 6'd3;
        start            = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (byte_req) break;
            @(negedge clk);
        end
        check_val("t6_req_seen", {63'd0, byte_req}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("t6_req", {63'd0, byte_req}, 64'd0);
        check_val("t6_busy", {63'd0, busy}, 64'd0);
        check_val("t6_done", {63'd0, done}, 64'd0);
        check_val("t6_bins", {32'd0, bins_out}, 64'd0);
        check_val("t6_value", {32'd0, m_value_out}, 64'd0);
        check_val("t6_bn", {60'd0, m_bits_needed_out}, 64'd0);
        rst_n = 1'b1;
        run_req(9'd256, 32'h0000_7FFF, 4'h8, 6'd4, 0, 8'h00, 1'b0);
        check_val("t6_rerun_bins", {32'd0, bins_out}, 64'hF);
        check_val("t6_rerun_value", {32'd0, m_value_out}, 64'h7FF0);
        check_val("t6_rerun_lat", 64'(lat), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
